// File: rtl/fre_calc.sv
// Frequency calculator: converts captured gate counts {cntclk, cntsqu} into Hz
// as cntsqu * CLK_FREQ / cntclk using a 32-step restoring divider.
module fre_calc #(
    parameter logic [31:0] CLK_FREQ = 32'd100_000_000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [31:0] cntclk,
    input  logic [31:0] cntsqu,
    output logic [31:0] freq_hz,
    output logic        freq_valid,
    output logic        busy,
    output logic        div_zero,
    output logic        overflow
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]      state, state_nxt;
    logic [W-1:0]    cap_clk, cap_clk_nxt;
    logic [W-1:0]    cap_squ, cap_squ_nxt;
    logic [2*W-1:0]  prod, prod_nxt;
    logic [W:0]      rem, rem_nxt;
    logic [W-1:0]    quot, quot_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            err_dz, err_dz_nxt;
    logic            err_ov, err_ov_nxt;
    logic [W-1:0]    freq_hz_nxt;
    logic            freq_valid_nxt, busy_nxt, div_zero_nxt, overflow_nxt;

    logic [2*W-1:0]  prod_c;
    logic            ge_c;
    logic [W:0]      rem_sub_c;

    assign prod_c = 64'(cap_squ) * 64'(CLK_FREQ);

    // Next-state and datapath update
    always_comb begin
        state_nxt      = state;
        cap_clk_nxt    = cap_clk;
        cap_squ_nxt    = cap_squ;
        prod_nxt       = prod;
        rem_nxt        = rem;
        quot_nxt       = quot;
        cnt_nxt        = cnt;
        err_dz_nxt     = err_dz;
        err_ov_nxt     = err_ov;
        freq_hz_nxt    = freq_hz;
        freq_valid_nxt = 1'b0;
        busy_nxt       = (state != IDLE);
        div_zero_nxt   = div_zero;
        overflow_nxt   = overflow;
        ge_c           = 1'b0;
        rem_sub_c      = rem;

        case (state)
            IDLE: begin
                // No upstream strobe: a changed pair is the start trigger
                if ({cntclk, cntsqu} != {cap_clk, cap_squ}) begin
                    cap_clk_nxt = cntclk;
                    cap_squ_nxt = cntsqu;
                    busy_nxt    = 1'b1;
                    state_nxt   = MUL;
                end
            end
            MUL: begin
                prod_nxt   = prod_c;
                rem_nxt    = {prod_c[2*W-1:W], prod_c[W-1]};
                quot_nxt   = '0;
                cnt_nxt    = '0;
                err_dz_nxt = (cap_clk == '0);
                err_ov_nxt = (cap_clk != '0) && (prod_c[2*W-1:W] >= cap_clk);
                state_nxt  = (err_dz_nxt || err_ov_nxt) ? DONE : DIV;
            end
            DIV: begin
                // rem holds the partial remainder with the next dividend bit already appended
                ge_c      = (rem >= {1'b0, cap_clk});
                rem_sub_c = ge_c ? (rem - {1'b0, cap_clk}) : rem;
                rem_nxt   = 33'({rem_sub_c, prod[W-2]});
                prod_nxt  = prod << 1;
                quot_nxt  = {quot[W-2:0], ge_c};
                cnt_nxt   = cnt + 5'd1;
                if (cnt == 5'd31) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                freq_valid_nxt = 1'b1;
                freq_hz_nxt    = err_dz ? 32'h0 : (err_ov ? 32'hFFFF_FFFF : quot);
                div_zero_nxt   = err_dz;
                overflow_nxt   = err_ov;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cap_clk    <= '0;
            cap_squ    <= '0;
            prod       <= '0;
            rem        <= '0;
            quot       <= '0;
            cnt        <= '0;
            err_dz     <= 1'b0;
            err_ov     <= 1'b0;
            freq_hz    <= '0;
            freq_valid <= 1'b0;
            busy       <= 1'b0;
            div_zero   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cap_clk    <= cap_clk_nxt;
            cap_squ    <= cap_squ_nxt;
            prod       <= prod_nxt;
            rem        <= rem_nxt;
            quot       <= quot_nxt;
            cnt        <= cnt_nxt;
            err_dz     <= err_dz_nxt;
            err_ov     <= err_ov_nxt;
            freq_hz    <= freq_hz_nxt;
            freq_valid <= freq_valid_nxt;
            busy       <= busy_nxt;
            div_zero   <= div_zero_nxt;
            overflow   <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_fre_calc.sv
// Scoreboard bench for fre_calc: stimulus pushes expected results, monitors pop on freq_valid.
module tb_fre_calc;

    typedef struct packed {
        logic [31:0] f;
        logic        dz;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst100_n = 1'b0;
    logic [31:0] cntclk = '0, cntsqu = '0;
    logic [31:0] freq_hz;
    logic        freq_valid, busy, div_zero, overflow;
    logic [31:0] c100clk = '0, c100squ = '0;
    logic [31:0] f100;
    logic        v100, b100, dz100, ov100;

    exp_t q[$];
    exp_t q100[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   vcount = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fre_calc #(.CLK_FREQ(32'd100_000_000)) dut (
        .clk_in(clk), .rst_n(rst_n), .cntclk(cntclk), .cntsqu(cntsqu),
        .freq_hz(freq_hz), .freq_valid(freq_valid), .busy(busy),
        .div_zero(div_zero), .overflow(overflow)
    );

    fre_calc #(.CLK_FREQ(32'd100)) dut100 (
        .clk_in(clk), .rst_n(rst100_n), .cntclk(c100clk), .cntsqu(c100squ),
        .freq_hz(f100), .freq_valid(v100), .busy(b100),
        .div_zero(dz100), .overflow(ov100)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Main-DUT monitor
    always @(negedge clk) begin
        exp_t e;
        if (freq_valid) begin
            vcount++;
            check("valid_single_cycle", 32'(prev_valid), 32'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got freq_hz=%0d with empty scoreboard", freq_hz);
            end else begin
                e = q.pop_front();
                check("freq_hz", freq_hz, e.f);
                check("div_zero", 32'(div_zero), 32'(e.dz));
                check("overflow", 32'(overflow), 32'(e.ov));
            end
        end
        prev_valid = freq_valid;
    end

    // CLK_FREQ=100 DUT monitor
    always @(negedge clk) begin
        exp_t e;
        if (v100) begin
            if (q100.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid100: got freq_hz=%0d with empty scoreboard", f100);
            end else begin
                e = q100.pop_front();
                check("freq_hz100", f100, e.f);
                check("div_zero100", 32'(dz100), 32'(e.dz));
                check("overflow100", 32'(ov100), 32'(e.ov));
            end
        end
    end

    task automatic wait_valid(output int at);
        at = -1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (freq_valid) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL valid_timeout: got no freq_valid within 200 cycles, required one");
        end
    endtask

    task automatic apply(input logic [31:0] c, input logic [31:0] s, input exp_t e, input int lat);
        int e0;
        int at;
        @(negedge clk);
        cntclk = c;
        cntsqu = s;
        q.push_back(e);
        e0 = cyc + 1;
        wait_valid(at);
        if (lat > 0 && at >= 0) check("latency", 32'(at - e0), 32'(lat));
        @(posedge clk);
        #1;
        check("busy_drop", 32'(busy), 32'd0);
    endtask

    initial begin
        int e0, a1, a2, v0, at;
        bit seen;
        repeat (3) @(negedge clk);
        check("rst_freq_hz", freq_hz, 32'd0);
        check("rst_valid", 32'(freq_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        rst100_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_busy", 32'(busy), 32'd0);

        apply(32'd100_000_000, 32'd1000, '{32'd1000, 1'b0, 1'b0}, 34);
        apply(32'd50_000_000, 32'd12_345, '{32'd24_690, 1'b0, 1'b0}, 34);

        // Same pair again: no new conversion
        v0 = vcount;
        @(negedge clk);
        cntclk = 32'd50_000_000;
        cntsqu = 32'd12_345;
        repeat (50) @(posedge clk);
        #1;
        check("no_reconvert", 32'(vcount - v0), 32'd0);
        check("no_reconvert_busy", 32'(busy), 32'd0);

        apply(32'd50_000_000, 32'd12_346, '{32'd24_692, 1'b0, 1'b0}, 34);
        apply(32'd0, 32'd5, '{32'd0, 1'b1, 1'b0}, 2);
        apply(32'd1, 32'hFFFF_FFFF, '{32'hFFFF_FFFF, 1'b0, 1'b1}, 2);
        apply(32'd1, 32'd42, '{32'd4_200_000_000, 1'b0, 1'b0}, 34);
        apply(32'd1, 32'd43, '{32'hFFFF_FFFF, 1'b0, 1'b1}, 2);
        apply(32'd7, 32'd3, '{32'd42_857_142, 1'b0, 1'b0}, 34);
        apply(32'd100_000_000, 32'd1000, '{32'd1000, 1'b0, 1'b0}, 34);

        // Truncation with CLK_FREQ = 100
        @(negedge clk);
        c100clk = 32'd3;
        c100squ = 32'd1;
        q100.push_back('{32'd33, 1'b0, 1'b0});
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(posedge clk);
            #1;
            seen = v100;
        end
        check("valid100_seen", 32'(seen), 32'd1);

        // Input change mid-conversion
        @(negedge clk);
        cntclk = 32'd40_000_000;
        cntsqu = 32'd1000;
        q.push_back('{32'd2500, 1'b0, 1'b0});
        e0 = cyc + 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        cntclk = 32'd30_000_000;
        cntsqu = 32'd77;
        q.push_back('{32'd256, 1'b0, 1'b0});
        wait_valid(a1);
        if (a1 >= 0) check("midchg_latency", 32'(a1 - e0), 32'd34);
        wait_valid(a2);
        if (a1 >= 0 && a2 >= 0) check("midchg_gap", 32'(a2 - a1), 32'd35);
        repeat (3) @(posedge clk);

        // Reset mid-conversion
        @(negedge clk);
        cntclk = 32'd25_000_000;
        cntsqu = 32'd999;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_freq_hz", freq_hz, 32'd0);
        check("abort_valid", 32'(freq_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_div_zero", 32'(div_zero), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        v0 = vcount;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q.push_back('{32'd3996, 1'b0, 1'b0});
        e0 = cyc + 1;
        wait_valid(at);
        if (at >= 0) check("restart_latency", 32'(at - e0), 32'd34);
        repeat (3) @(negedge clk);
        check("restart_one_valid", 32'(vcount - v0), 32'd1);

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        check("scoreboard100_empty", 32'(q100.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
